// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution feed controller.
//   state_e   - frame sequencer state encoding
//   PADDED(x) - size of a dimension once the one-pixel zero border is added
//   clog2(v)  - bits needed to count 0..v-1, used for counter widths
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TOP_PAD,
        LPAD,
        DATA,
        RPAD,
        BOT_PAD,
        DONE
    } state_e;

    function automatic int PADDED(input int x);
        return x + 2;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/pad_counter.sv
// pad_counter: column/row position inside the zero-bordered frame.
//   clk, Rst     - clock, synchronous active-high reset
//   clr_i        - return to (row 0, col 0), used when a frame starts
//   inc_i        - advance one beat
//   col_o, row_o - current padded position
//   col_wrap_o   - col is on the last padded column (W+1)
//   last_row_o   - row is on the last active row (H)
module pad_counter
    import conv_pkg::*;
#(
    parameter int W = 480,
    parameter int H = 480,
    localparam int CW = clog2(PADDED(W)),
    localparam int RW = clog2(PADDED(H))
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          col_wrap_o,
    output logic          last_row_o
);

    localparam logic [CW-1:0] COL_LAST = CW'(W + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H + 1);
    localparam logic [RW-1:0] ROW_H    = RW'(H);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    assign col_wrap_o = (col_q == COL_LAST);
    assign last_row_o = (row_q == ROW_H);
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_ff @(posedge clk) begin
        if (Rst || clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (inc_i) begin
            if (col_wrap_o) begin
                col_q <= '0;
                // Leaving the bottom border puts the pair back at the origin.
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_feed_ctrl.sv
// conv_feed_ctrl: turns an unpadded W x H RGB stream into the (W+2) x (H+2)
// zero-bordered beat stream the 3-channel convolution expects.
//   clk, Rst                 - clock, synchronous active-high reset
//   start                    - begin one frame (only while idle)
//   s_r/s_g/s_b, s_valid,
//   s_sof, s_ready           - upstream pixel handshake
//   conv_r/g/b, conv_valid,
//   conv_repeat              - registered beat stream to the convolution
//   busy, frame_done, sof_err - frame-level status
module conv_feed_ctrl
    import conv_pkg::*;
#(
    parameter int M = 8,
    parameter int W = 480,
    parameter int H = 480
) (
    input  logic         clk,
    input  logic         Rst,
    input  logic         start,
    input  logic [M-1:0] s_r,
    input  logic [M-1:0] s_g,
    input  logic [M-1:0] s_b,
    input  logic         s_valid,
    input  logic         s_sof,
    output logic         s_ready,
    output logic [M-1:0] conv_r,
    output logic [M-1:0] conv_g,
    output logic [M-1:0] conv_b,
    output logic         conv_valid,
    output logic         conv_repeat,
    output logic         busy,
    output logic         frame_done,
    output logic         sof_err
);

    localparam int CW = clog2(PADDED(W));
    localparam int RW = clog2(PADDED(H));

    state_e        state_q, state_d;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_wrap, last_row;
    logic          beat, xfer, first_px, clr;

    logic [M-1:0]  conv_r_q, conv_g_q, conv_b_q;
    logic          conv_valid_q, conv_repeat_q;
    logic          s_ready_q, busy_q, frame_done_q, sof_err_q;

    pad_counter #(.W(W), .H(H)) u_cnt (
        .clk        (clk),
        .Rst        (Rst),
        .clr_i      (clr),
        .inc_i      (beat),
        .col_o      (col),
        .row_o      (row),
        .col_wrap_o (col_wrap),
        .last_row_o (last_row)
    );

    // s_ready_q is high exactly while in DATA, so this is the handshake.
    assign xfer     = (state_q == DATA) && s_valid;
    assign first_px = (row == RW'(1)) && (col == CW'(1));
    assign clr      = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        beat    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = TOP_PAD;
            TOP_PAD: begin
                beat = 1'b1;
                if (col_wrap) state_d = LPAD;
            end
            LPAD: begin
                beat    = 1'b1;
                state_d = DATA;
            end
            DATA: if (s_valid) begin
                beat = 1'b1;
                if (col == CW'(W)) state_d = RPAD;
            end
            RPAD: begin
                beat    = 1'b1;
                state_d = last_row ? BOT_PAD : LPAD;
            end
            BOT_PAD: begin
                beat = 1'b1;
                if (col_wrap) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q       <= IDLE;
            s_ready_q     <= 1'b0;
            conv_r_q      <= '0;
            conv_g_q      <= '0;
            conv_b_q      <= '0;
            conv_valid_q  <= 1'b0;
            conv_repeat_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            sof_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= (state_d == DATA);
            busy_q        <= (state_d != IDLE);
            frame_done_q  <= (state_q == DONE);
            conv_valid_q  <= beat;
            // Bottom border beats flush the convolution line buffers.
            conv_repeat_q <= beat && (state_q == BOT_PAD);
            // Pad beats and idle cycles both carry zero data.
            conv_r_q      <= xfer ? s_r : '0;
            conv_g_q      <= xfer ? s_g : '0;
            conv_b_q      <= xfer ? s_b : '0;
            // SOF must be set on the first pixel and only there.
            if (clr)
                sof_err_q <= 1'b0;
            else if (xfer && (first_px != s_sof))
                sof_err_q <= 1'b1;
        end
    end

    assign s_ready     = s_ready_q;
    assign conv_r      = conv_r_q;
    assign conv_g      = conv_g_q;
    assign conv_b      = conv_b_q;
    assign conv_valid  = conv_valid_q;
    assign conv_repeat = conv_repeat_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign sof_err     = sof_err_q;

endmodule
